// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and a baud-divider helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_rx_state_t;

  // Rounded clk cycles per oversample tick; usable in localparam expressions.
  function automatic int calc_clk_div(input int clk_hz, input int baud, input int ovs);
    return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// One-cycle enable pulse every DIV clocks; clr restarts the period so phase follows an external event.
module uart_tick_gen #(
  parameter int DIV = 130
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with configurable framing, error flags and a one-word holding register.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int      CLK_DIV   = 130,
  parameter int      OVS       = 16,
  parameter int      DATA_BITS = 8,
  parameter parity_t PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           o_dbg_state
);

  localparam int TCW = $clog2(OVS);
  localparam logic [TCW-1:0] HALF_LAST = TCW'(OVS / 2 - 1);
  localparam logic [TCW-1:0] FULL_LAST = TCW'(OVS - 1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

  logic                 r_sync1, r_sync2;
  logic                 w_rxs;
  uart_rx_state_t       r_state, w_state_next;
  logic [TCW-1:0]       r_tick_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr, r_ferr;
  logic                 w_tick, w_clr, w_sample, w_done, w_ferr_final, w_par_bad, w_hs;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_perr_hold, r_ferr_hold, r_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rxs = r_sync2;

  uart_tick_gen #(.DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // Start bit is sampled half a bit in; every later bit one full bit after that.
  assign w_sample = w_tick &&
    (((r_state == ST_START) && (r_tick_cnt == HALF_LAST)) ||
     (((r_state == ST_DATA) || (r_state == ST_PARITY) || (r_state == ST_STOP)) &&
      (r_tick_cnt == FULL_LAST)));

  assign w_ferr_final = r_ferr || !w_rxs;
  assign w_par_bad    = (^r_shift) ^ w_rxs ^ (PARITY == PAR_ODD);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rxs) begin
          w_state_next = ST_START;
          w_clr        = 1'b1;
        end
      end
      ST_START: begin
        if (w_sample) w_state_next = w_rxs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_sample && (r_bit_cnt == DATA_LAST))
          w_state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_sample) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_sample && (r_bit_cnt == STOP_LAST)) begin
          w_done       = 1'b1;
          w_state_next = w_ferr_final ? ST_WAIT_HIGH : ST_IDLE;
        end
      end
      ST_WAIT_HIGH: begin
        if (w_rxs) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      if (w_clr || w_sample) r_tick_cnt <= '0;
      else if (w_tick)       r_tick_cnt <= r_tick_cnt + 1'b1;

      if (w_state_next != r_state) r_bit_cnt <= '0;
      else if (w_sample)           r_bit_cnt <= r_bit_cnt + 1'b1;

      if (w_clr) begin
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (w_sample && (r_state == ST_DATA))   r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
      if (w_sample && (r_state == ST_PARITY)) r_perr  <= w_par_bad;
      if (w_sample && (r_state == ST_STOP) && !w_rxs) r_ferr <= 1'b1;
    end
  end

  // valid/ready: a word is transferred in any cycle where valid && ready; data and flags stay
  // frozen while valid is high, and a completed frame may reload in the same cycle as a transfer.
  assign w_hs = r_valid && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_perr_hold <= 1'b0;
      r_ferr_hold <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_done && (!r_valid || w_hs)) begin
        r_data      <= r_shift;
        r_perr_hold <= r_perr;
        r_ferr_hold <= w_ferr_final;
        r_valid     <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end

      if (w_done && r_valid && !ready) r_overrun <= 1'b1;
      else if (w_hs)                   r_overrun <= 1'b0;
    end
  end

  assign data        = r_data;
  assign valid       = r_valid;
  assign parity_err  = r_perr_hold;
  assign frame_err   = r_ferr_hold;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: three framings (8N1, 8E1, 7O2) driven bit-by-bit, with a scoreboard per receiver.
module tb_uart_rx_ovs;
  import uart_pkg::*;

  localparam int BIT_CLKS = 4 * 16;

  logic       clk;
  logic       reset;
  logic [2:0] rx_v;
  logic [2:0] rdy_v;

  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic       valid0, valid1, valid2;
  logic       perr0, perr1, perr2;
  logic       ferr0, ferr1, ferr2;
  logic       ovr0, ovr1, ovr2;
  logic [2:0] dbg0, dbg1, dbg2;

  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic [10:0] exp_q2[$];

  int n_checks;
  int n_errors;

  uart_rx_ovs #(.CLK_DIV(4), .OVS(16), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .rx(rx_v[0]), .data(data0), .valid(valid0), .ready(rdy_v[0]),
    .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0), .o_dbg_state(dbg0));

  uart_rx_ovs #(.CLK_DIV(4), .OVS(16), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .rx(rx_v[1]), .data(data1), .valid(valid1), .ready(rdy_v[1]),
    .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1), .o_dbg_state(dbg1));

  uart_rx_ovs #(.CLK_DIV(4), .OVS(16), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .rx(rx_v[2]), .data(data2), .valid(valid2), .ready(rdy_v[2]),
    .parity_err(perr2), .frame_err(ferr2), .overrun(ovr2), .o_dbg_state(dbg2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // framing per receiver: data bits, parity mode (0 none, 1 even, 2 odd), stop bits
  function automatic int cfg_bits(input int idx);
    return (idx == 2) ? 7 : 8;
  endfunction
  function automatic int cfg_par(input int idx);
    return idx;
  endfunction
  function automatic int cfg_stop(input int idx);
    return (idx == 2) ? 2 : 1;
  endfunction

  task automatic push_exp(input int idx, input logic [10:0] e);
    case (idx)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // driver tasks
  task automatic drive_bit(input int idx, input logic b);
    rx_v[idx] = b;
    wait_clk(BIT_CLKS);
  endtask

  task automatic send_frame(input int idx, input int d, input bit good_par,
                            input logic [1:0] stop_v, input bit push);
    int         nb, pm, ns;
    logic [8:0] dm;
    logic       pbit, ferr_e, perr_e;
    nb     = cfg_bits(idx);
    pm     = cfg_par(idx);
    ns     = cfg_stop(idx);
    dm     = 9'(d & ((1 << nb) - 1));
    pbit   = (pm == 1) ? (^dm) : ~(^dm);
    if (!good_par) pbit = ~pbit;
    perr_e = (pm != 0) && !good_par;
    ferr_e = (stop_v[0] == 1'b0) || ((ns == 2) && (stop_v[1] == 1'b0));
    if (push) push_exp(idx, {dm, perr_e, ferr_e});
    drive_bit(idx, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(idx, dm[i]);
    if (pm != 0) drive_bit(idx, pbit);
    for (int i = 0; i < ns; i++) drive_bit(idx, stop_v[i]);
  endtask

  // scoreboard monitor
  task automatic mon_pop(input int idx, input logic [8:0] d, input logic pe, input logic fe);
    logic [10:0] e;
    bit          have;
    have = 1'b0;
    e    = '0;
    case (idx)
      0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_checks++;
      n_errors++;
      $display("FAIL u%0d_unexpected_frame: got data %0h, expected no frame", idx, d);
    end else begin
      check($sformatf("u%0d_data", idx), 32'(d), 32'(e[10:2]));
      check($sformatf("u%0d_parity_err", idx), 32'(pe), 32'(e[1]));
      check($sformatf("u%0d_frame_err", idx), 32'(fe), 32'(e[0]));
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (valid0 && rdy_v[0]) mon_pop(0, {1'b0, data0}, perr0, ferr0);
      if (valid1 && rdy_v[1]) mon_pop(1, {1'b0, data1}, perr1, ferr1);
      if (valid2 && rdy_v[2]) mon_pop(2, {2'b0, data2}, perr2, ferr2);
    end
  end

  task automatic pulse_ready0;
    @(negedge clk);
    rdy_v[0] = 1'b1;
    @(negedge clk);
    rdy_v[0] = 1'b0;
    #2;
  endtask

  initial begin
    int         d, gap;
    bit         good;
    logic [1:0] sv;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    rx_v     = 3'b111;
    rdy_v    = 3'b000;

    wait_clk(5);
    #2;
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_data", 32'(data0), 32'd0);
    check("rst_parity_err", 32'(perr1), 32'd0);
    check("rst_frame_err", 32'(ferr2), 32'd0);
    check("rst_overrun", 32'(ovr0), 32'd0);
    check("rst_state", 32'(dbg0), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    wait_clk(10);

    // 8N1 0xA5 held with ready low
    send_frame(0, 8'hA5, 1'b1, 2'b11, 1'b1);
    wait_clk(5);
    #2;
    check("a5_valid", 32'(valid0), 32'd1);
    check("a5_data", 32'(data0), 32'hA5);
    check("a5_errs", 32'({perr0, ferr0}), 32'd0);
    wait_clk(100);
    #2;
    check("a5_still_valid", 32'(valid0), 32'd1);
    check("a5_still_data", 32'(data0), 32'hA5);
    pulse_ready0();
    check("a5_valid_cleared", 32'(valid0), 32'd0);

    // parity frames
    rdy_v[1] = 1'b1;
    rdy_v[2] = 1'b1;
    send_frame(1, 8'h03, 1'b0, 2'b11, 1'b1);
    wait_clk(20);
    send_frame(1, 8'h03, 1'b1, 2'b11, 1'b1);
    wait_clk(20);
    send_frame(2, 7'h7F, 1'b1, 2'b11, 1'b1);
    wait_clk(20);
    send_frame(2, 7'h7F, 1'b0, 2'b11, 1'b1);
    wait_clk(20);

    // false start then a real frame
    rdy_v[0] = 1'b1;
    rx_v[0]  = 1'b0;
    wait_clk(20);
    rx_v[0] = 1'b1;
    wait_clk(60);
    #2;
    check("false_start_state", 32'(dbg0), 32'(ST_IDLE));
    check("false_start_valid", 32'(valid0), 32'd0);
    send_frame(0, 8'h3C, 1'b1, 2'b11, 1'b1);
    wait_clk(20);

    // break: low stop bit, line held low for 20 bit times
    send_frame(0, 8'h55, 1'b1, 2'b00, 1'b1);
    wait_clk(20 * BIT_CLKS);
    #2;
    check("break_state", 32'(dbg0), 32'(ST_WAIT_HIGH));
    check("break_valid", 32'(valid0), 32'd0);
    rx_v[0] = 1'b1;
    wait_clk(BIT_CLKS);
    send_frame(0, 8'h66, 1'b1, 2'b11, 1'b1);
    wait_clk(20);

    // overrun
    rdy_v[0] = 1'b0;
    send_frame(0, 8'h11, 1'b1, 2'b11, 1'b1);
    send_frame(0, 8'h22, 1'b1, 2'b11, 1'b0);
    wait_clk(5);
    #2;
    check("ovr_flag", 32'(ovr0), 32'd1);
    check("ovr_data", 32'(data0), 32'h11);
    check("ovr_valid", 32'(valid0), 32'd1);
    pulse_ready0();
    check("ovr_valid_cleared", 32'(valid0), 32'd0);
    check("ovr_flag_cleared", 32'(ovr0), 32'd0);

    // held error word, then reset in the middle of 0xF0
    send_frame(0, 8'h81, 1'b1, 2'b10, 1'b0);
    wait_clk(10);
    #2;
    check("held_ferr", 32'(ferr0), 32'd1);
    check("held_data", 32'(data0), 32'h81);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
    wait_clk(30);
    reset   = 1'b1;
    rx_v[0] = 1'b1;
    @(negedge clk);
    #2;
    check("midrst_valid", 32'(valid0), 32'd0);
    check("midrst_data", 32'(data0), 32'd0);
    check("midrst_flags", 32'({perr0, ferr0, ovr0}), 32'd0);
    check("midrst_state", 32'(dbg0), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    wait_clk(10);
    rdy_v[0] = 1'b1;
    send_frame(0, 8'h0F, 1'b1, 2'b11, 1'b1);
    wait_clk(20);

    // randomized frames, sometimes back-to-back
    for (int idx = 0; idx < 3; idx++) begin
      for (int k = 0; k < 8; k++) begin
        gap  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 100));
        d    = int'($urandom_range(0, 511));
        good = ($urandom_range(0, 3) != 0);
        sv   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        if (gap > 0) wait_clk(gap);
        send_frame(idx, d, good, sv, 1'b1);
        if (sv != 2'b11) begin
          rx_v[idx] = 1'b1;
          wait_clk(BIT_CLKS);
        end
      end
    end

    // drain
    for (int t = 0; t < 2000; t++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0 && exp_q2.size() == 0) break;
      @(negedge clk);
    end
    wait_clk(5);
    check("drain_q0", 32'(exp_q0.size()), 32'd0);
    check("drain_q1", 32'(exp_q1.size()), 32'd0);
    check("drain_q2", 32'(exp_q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
